// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light safety monitor.
package traffic_pkg;

  typedef enum logic [1:0] {
    START   = 2'd0,
    MONITOR = 2'd1,
    FLASH   = 2'd2
  } state_t;

  localparam logic [2:0] FC_NONE  = 3'd0;
  localparam logic [2:0] FC_CROSS = 3'd1;
  localparam logic [2:0] FC_WALK  = 3'd2;
  localparam logic [2:0] FC_DARK  = 3'd3;
  localparam logic [2:0] FC_SEQ   = 3'd4;

  // One lamp command set: main road, side road, walk.
  typedef struct packed {
    logic rm;
    logic ym;
    logic gm;
    logic rs;
    logic ys;
    logic gs;
    logic w;
  } lamps_t;

  localparam lamps_t ALL_RED = '{rm: 1'b1, ym: 1'b0, gm: 1'b0,
                                 rs: 1'b1, ys: 1'b0, gs: 1'b0, w: 1'b0};

  // True when exactly one of the three lamps of a road is lit.
  function automatic logic one_hot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/lamp_rule_checker.sv
// Combinational level-rule check on one lamp set; lowest code wins.
module lamp_rule_checker
  import traffic_pkg::*;
(
  input  lamps_t     lamps,
  output logic       violation_c,
  output logic [2:0] code_c
);

  logic main_go;
  logic side_go;

  // Prioritised level rule evaluation.
  always_comb begin
    main_go = lamps.gm | lamps.ym;
    side_go = lamps.gs | lamps.ys;
    code_c  = FC_NONE;
    if (main_go && side_go) begin
      code_c = FC_CROSS;
    end else if (lamps.w && (main_go || side_go)) begin
      code_c = FC_WALK;
    end else if (!one_hot3({lamps.rm, lamps.ym, lamps.gm}) ||
                 !one_hot3({lamps.rs, lamps.ys, lamps.gs})) begin
      code_c = FC_DARK;
    end
    violation_c = (code_c != FC_NONE);
  end

endmodule

// File: rtl/conflict_monitor.sv
// Safety stage between the signal controller and the lamp drivers.
module conflict_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned CONFLICT_CYCLES = 4,
  parameter int unsigned STARTUP_CYCLES  = 16,
  parameter int unsigned FLASH_HALF      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Rm,
  input  logic       Ym,
  input  logic       Gm,
  input  logic       Rs,
  input  logic       Ys,
  input  logic       Gs,
  input  logic       W,
  input  logic       clear_fault,
  output logic       Rm_out,
  output logic       Ym_out,
  output logic       Gm_out,
  output logic       Rs_out,
  output logic       Ys_out,
  output logic       Gs_out,
  output logic       W_out,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int unsigned VW = $clog2(CONFLICT_CYCLES) + 1;
  localparam int unsigned SW = $clog2(STARTUP_CYCLES) + 1;
  localparam int unsigned FW = $clog2(FLASH_HALF) + 1;

  state_t        state_q, state_d;
  lamps_t        samp_q, samp_d;
  logic          hist_gm_q, hist_gm_d;
  logic          hist_gs_q, hist_gs_d;
  logic          seq_en_q, seq_en_d;
  logic [SW-1:0] start_cnt_q, start_cnt_d;
  logic [VW-1:0] viol_cnt_q, viol_cnt_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          phase_q, phase_d;
  logic [2:0]    code_q, code_d;
  lamps_t        out_q, out_d;
  logic          fault_q, fault_d;
  logic [2:0]    fault_code_q, fault_code_d;

  logic          level_viol_c;
  logic [2:0]    level_code_c;
  logic          seq_viol_c;

  lamp_rule_checker u_rules (
    .lamps       (samp_q),
    .violation_c (level_viol_c),
    .code_c      (level_code_c)
  );

  // Next-state, counters, history and registered output values.
  always_comb begin
    samp_d       = lamps_t'({Rm, Ym, Gm, Rs, Ys, Gs, W});
    hist_gm_d    = samp_q.gm;
    hist_gs_d    = samp_q.gs;
    seq_en_d     = (state_q == MONITOR);
    state_d      = state_q;
    start_cnt_d  = start_cnt_q;
    viol_cnt_d   = viol_cnt_q;
    flash_cnt_d  = flash_cnt_q;
    phase_d      = phase_q;
    code_d       = code_q;
    out_d        = ALL_RED;
    fault_d      = 1'b0;
    fault_code_d = FC_NONE;
    // History is only trusted once a full MONITOR cycle has loaded it.
    seq_viol_c   = seq_en_q & ((hist_gm_q & samp_q.rm) | (hist_gs_q & samp_q.rs));

    case (state_q)
      START: begin
        viol_cnt_d = '0;
        if (start_cnt_q == SW'(STARTUP_CYCLES)) begin
          state_d     = MONITOR;
          start_cnt_d = '0;
        end else begin
          start_cnt_d = start_cnt_q + SW'(1);
        end
      end
      MONITOR: begin
        out_d = samp_q;
        if (seq_viol_c) begin
          state_d     = FLASH;
          code_d      = FC_SEQ;
          phase_d     = 1'b1;
          flash_cnt_d = '0;
          viol_cnt_d  = '0;
        end else if (level_viol_c) begin
          if (viol_cnt_q == VW'(CONFLICT_CYCLES - 1)) begin
            state_d     = FLASH;
            code_d      = level_code_c;
            phase_d     = 1'b1;
            flash_cnt_d = '0;
            viol_cnt_d  = '0;
          end else begin
            viol_cnt_d = viol_cnt_q + VW'(1);
          end
        end else begin
          viol_cnt_d = '0;
        end
      end
      FLASH: begin
        out_d        = '0;
        out_d.rm     = phase_q;
        out_d.rs     = phase_q;
        fault_d      = 1'b1;
        fault_code_d = code_q;
        if (clear_fault && !level_viol_c) begin
          state_d     = START;
          start_cnt_d = '0;
          viol_cnt_d  = '0;
          flash_cnt_d = '0;
          phase_d     = 1'b0;
          code_d      = FC_NONE;
        end else if (flash_cnt_q == FW'(FLASH_HALF - 1)) begin
          flash_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          flash_cnt_d = flash_cnt_q + FW'(1);
        end
      end
      default: state_d = START;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= START;
      samp_q       <= '0;
      hist_gm_q    <= 1'b0;
      hist_gs_q    <= 1'b0;
      seq_en_q     <= 1'b0;
      start_cnt_q  <= '0;
      viol_cnt_q   <= '0;
      flash_cnt_q  <= '0;
      phase_q      <= 1'b0;
      code_q       <= FC_NONE;
      out_q        <= ALL_RED;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      samp_q       <= samp_d;
      hist_gm_q    <= hist_gm_d;
      hist_gs_q    <= hist_gs_d;
      seq_en_q     <= seq_en_d;
      start_cnt_q  <= start_cnt_d;
      viol_cnt_q   <= viol_cnt_d;
      flash_cnt_q  <= flash_cnt_d;
      phase_q      <= phase_d;
      code_q       <= code_d;
      out_q        <= out_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign Rm_out     = out_q.rm;
  assign Ym_out     = out_q.ym;
  assign Gm_out     = out_q.gm;
  assign Rs_out     = out_q.rs;
  assign Ys_out     = out_q.ys;
  assign Gs_out     = out_q.gs;
  assign W_out      = out_q.w;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_conflict_monitor.sv
// Self-checking bench for conflict_monitor: timeline model plus literal spot checks.
module tb_conflict_monitor;

  localparam int C  = 4;
  localparam int S  = 16;
  localparam int FH = 8;

  // Vector order {Rm,Ym,Gm,Rs,Ys,Gs,W}
  localparam logic [6:0] GMRS   = 7'b0011000;
  localparam logic [6:0] YMRS   = 7'b0101000;
  localparam logic [6:0] RMRS   = 7'b1001000;
  localparam logic [6:0] RMRS_W = 7'b1001001;
  localparam logic [6:0] RMGS   = 7'b1000010;
  localparam logic [6:0] RMYS   = 7'b1000100;
  localparam logic [6:0] YMGS   = 7'b0100010;
  localparam logic [6:0] GMGS   = 7'b0010010;
  localparam logic [6:0] WALK   = 7'b0000011;

  logic clk, reset, clear_fault;
  logic Rm, Ym, Gm, Rs, Ys, Gs, W;
  logic Rm_out, Ym_out, Gm_out, Rs_out, Ys_out, Gs_out, W_out, fault;
  logic [2:0] fault_code;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  conflict_monitor #(.CONFLICT_CYCLES(C), .STARTUP_CYCLES(S), .FLASH_HALF(FH)) dut (
    .clk(clk), .reset(reset),
    .Rm(Rm), .Ym(Ym), .Gm(Gm), .Rs(Rs), .Ys(Ys), .Gs(Gs), .W(W),
    .clear_fault(clear_fault),
    .Rm_out(Rm_out), .Ym_out(Ym_out), .Gm_out(Gm_out), .Rs_out(Rs_out),
    .Ys_out(Ys_out), .Gs_out(Gs_out), .W_out(W_out),
    .fault(fault), .fault_code(fault_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Level-rule code straight from the lamp-combination rules.
  function automatic int code_of(input logic [6:0] v);
    int main_on, side_on;
    bit main_go, side_go;
    main_on = int'(v[6]) + int'(v[5]) + int'(v[4]);
    side_on = int'(v[3]) + int'(v[2]) + int'(v[1]);
    main_go = v[5] | v[4];
    side_go = v[2] | v[1];
    if (main_go && side_go) return 1;
    if (v[0] && (main_go || side_go)) return 2;
    if (main_on != 1 || side_on != 1) return 3;
    return 0;
  endfunction

  // Timeline model: n = edges since reset release, s1 = input sampled at edge n-1.
  int n, start_edge, run_len, flash_edge, fcode, i;
  logic [6:0] s1, s2, cur, exp_out;
  int exp_fault, exp_code;

  always @(posedge clk) begin
    if (reset) begin
      n = 0; start_edge = 0; run_len = 0; flash_edge = -1; fcode = 0;
      s1 = '0; s2 = '0;
      exp_out = RMRS; exp_fault = 0; exp_code = 0;
    end else begin
      n++;
      cur = {Rm, Ym, Gm, Rs, Ys, Gs, W};
      if (flash_edge >= 0) begin
        i = n - 1 - flash_edge;
        exp_out   = (((i / FH) % 2) == 0) ? RMRS : 7'b0;
        exp_fault = 1;
        exp_code  = fcode;
        if (clear_fault && code_of(s1) == 0) begin
          start_edge = n; flash_edge = -1; run_len = 0;
        end
      end else if (n - 1 >= start_edge + S + 1) begin
        exp_out = s1; exp_fault = 0; exp_code = 0;
        if ((n - 1 >= start_edge + S + 2) && ((s2[4] && s1[6]) || (s2[1] && s1[3]))) begin
          flash_edge = n; fcode = 4; run_len = 0;
        end else if (code_of(s1) != 0) begin
          run_len++;
          if (run_len == C) begin
            flash_edge = n; fcode = code_of(s1); run_len = 0;
          end
        end else begin
          run_len = 0;
        end
      end else begin
        exp_out = RMRS; exp_fault = 0; exp_code = 0; run_len = 0;
      end
      s2 = s1;
      s1 = cur;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("lamps", int'({Rm_out, Ym_out, Gm_out, Rs_out, Ys_out, Gs_out, W_out}), int'(exp_out));
      check("fault", int'(fault), exp_fault);
      check("fault_code", int'(fault_code), exp_code);
    end
  end

  task automatic apply(input logic [6:0] v, input int cyc);
    repeat (cyc) begin
      @(negedge clk);
      {Rm, Ym, Gm, Rs, Ys, Gs, W} = v;
    end
  endtask

  task automatic legal_cycle();
    apply(GMRS, 4); apply(YMRS, 2); apply(RMRS_W, 3);
    apply(RMGS, 4); apply(RMYS, 2); apply(RMRS_W, 3);
  endtask

  initial begin
    reset = 1'b1; clear_fault = 1'b0;
    {Rm, Ym, Gm, Rs, Ys, Gs, W} = RMRS;
    repeat (3) @(posedge clk);
    #2;
    check("reset_lamps", int'({Rm_out, Ym_out, Gm_out, Rs_out, Ys_out, Gs_out, W_out}), 'h48);
    check("reset_fault", int'({fault, fault_code}), 0);
    @(negedge clk);
    reset = 1'b0;
    {Rm, Ym, Gm, Rs, Ys, Gs, W} = GMRS;
    chk_en = 1'b1;

    // Startup hold then first pass-through at edge S+2
    apply(GMRS, 16);
    @(posedge clk); #2;
    check("startup_allred", int'({Rm_out, Gm_out}), 2);
    @(posedge clk); #2;
    check("first_passthru", int'({Rm_out, Gm_out}), 1);
    legal_cycle();
    legal_cycle();
    #1 check("legal_no_fault", int'(fault), 0);

    // 3-cycle cross conflict is filtered out
    apply(RMGS, 3); apply(YMGS, 3); apply(RMGS, 6);
    #1 check("filter_no_fault", int'(fault), 0);

    // 4-cycle Gm+Gs conflict latches code 1 and flashes
    apply(RMYS, 2); apply(RMRS, 2); apply(GMRS, 3);
    apply(GMGS, 4);
    repeat (2) @(posedge clk); #2;
    check("cross_pre_fault", int'(fault), 0);
    @(posedge clk); #2;
    check("cross_fault", int'({fault, fault_code}), 'h9);
    check("flash_high", int'({Rm_out, Ym_out, Gm_out, Rs_out, Ys_out, Gs_out, W_out}), 'h48);
    repeat (8) @(posedge clk); #2;
    check("flash_low", int'({Rm_out, Rs_out}), 0);
    repeat (8) @(posedge clk); #2;
    check("flash_high2", int'({Rm_out, Rs_out}), 3);

    // Clear while inputs illegal is ignored; legal clear restarts
    clear_fault = 1'b1;
    apply(GMGS, 3);
    @(posedge clk); #2;
    check("clear_ignored", int'({fault, fault_code}), 'h9);
    apply(RMRS, 3);
    clear_fault = 1'b0;
    apply(RMRS, 2);
    #1 check("cleared", int'({fault, fault_code, Rm_out, Rs_out}), 3);
    apply(RMRS, 16);
    legal_cycle();

    // Walk with side green and dark main: code 2
    apply(RMGS, 2); apply(WALK, 4);
    repeat (3) @(posedge clk); #2;
    check("walk_fault", int'({fault, fault_code}), 'hA);
    clear_fault = 1'b1;
    apply(RMGS, 3);
    clear_fault = 1'b0;
    apply(RMGS, 20);

    // Main green straight to red: code 4 two edges after
    apply(RMYS, 2); apply(RMRS, 2); apply(GMRS, 5); apply(RMRS, 1);
    repeat (2) @(posedge clk); #2;
    check("seq_pre_fault", int'({fault, Rm_out}), 1);
    @(posedge clk); #2;
    check("seq_fault", int'({fault, fault_code}), 'hC);

    // Asynchronous reset mid-flash
    repeat (3) @(posedge clk); #3;
    check("flash_before_reset", int'(fault), 1);
    reset = 1'b1;
    #1;
    check("async_reset_lamps", int'({Rm_out, Ym_out, Gm_out, Rs_out, Ys_out, Gs_out, W_out}), 'h48);
    check("async_reset_fault", int'({fault, fault_code}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    {Rm, Ym, Gm, Rs, Ys, Gs, W} = GMRS;
    apply(GMRS, 20);
    apply(YMRS, 2);
    apply(RMRS, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
